// File: rtl/sc_sng_bank_if.sv
// sc_sng_bank_if: handshake/data bundle for the stochastic number generator bank.
//   start       - request a new window (snapshot of tap_in)
//   tap_in      - TAPS unsigned W-bit tap values
//   sc_out      - one registered bitstream bit per tap
//   sc_valid    - sc_out carries a window bit this cycle
//   window_done - pulse on the last bit of a window
//   busy        - generator FSM is in RUN
interface sc_sng_bank_if #(
  parameter int TAPS = 39,
  parameter int W    = 8
);
  logic                start;
  logic [W-1:0]        tap_in [TAPS-1:0];
  logic [TAPS-1:0]     sc_out;
  logic                sc_valid;
  logic                window_done;
  logic                busy;

  modport master (output start, tap_in,
                  input  sc_out, sc_valid, window_done, busy);
  modport slave  (input  start, tap_in,
                  output sc_out, sc_valid, window_done, busy);
endinterface

// File: rtl/sc_sng_bank.sv
// sc_sng_bank: converts a snapshot of TAPS binary tap values into 2^W-cycle
// unipolar bitstreams. One shared de Bruijn-extended LFSR walks every W-bit
// value exactly once per window, so tap[i] > rsel yields exactly tap[i] ones.
// Odd lanes compare against the bit-reversed random word to decorrelate
// neighbouring streams.
// Ports:
//   clk_i, rst_i - rising-edge clock, asynchronous active-high reset
//   bus          - sc_sng_bank_if.slave (start/tap_in in, sc_out/sc_valid/
//                  window_done/busy out, all outputs registered)

// Per-lane comparator with registered output bit.
module sc_sng_lane #(
  parameter int W   = 8,
  parameter bit REV = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] tap_i,
  input  logic [W-1:0] rnd_i,
  output logic         sc_o
);
  logic [W-1:0] rsel;

  always_comb begin
    rsel = rnd_i;
    if (REV)
      for (int b = 0; b < W; b++) rsel[b] = rnd_i[W-1-b];
  end

  // Forced low outside a window so consumers may OR/AND freely.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) sc_o <= 1'b0;
    else       sc_o <= en_i & (tap_i > rsel);
endmodule

module sc_sng_bank #(
  parameter int           TAPS = 39,
  parameter int           W    = 8,
  parameter logic [W-1:0] POLY = 8'hB8,
  parameter logic [W-1:0] SEED = 8'h01
) (
  input  logic          clk_i,
  input  logic          rst_i,
  sc_sng_bank_if.slave  bus
);
  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [W-1:0]    rnd_q, rnd_d;
  logic [W-1:0]    tap_q [TAPS-1:0];
  logic [W-1:0]    tap_d [TAPS-1:0];
  logic            valid_q, done_q;
  logic [TAPS-1:0] sc_q;
  logic            last, latch, fb, run;

  assign run  = (state_q == S_RUN);
  assign last = (cnt_q == {W{1'b1}});

  // Plain LFSR skips the all-zero state; the zero-detect term splices it in
  // between 10..0 and 0..01, giving a full 2^W cycle.
  assign fb = (^(rnd_q & POLY)) ^ (rnd_q[W-2:0] == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rnd_d   = rnd_q;
    tap_d   = tap_q;
    latch   = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.start) begin
        latch   = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        rnd_d = {rnd_q[W-2:0], fb};
        // start is only honoured on the final compare (back-to-back windows).
        if (last) begin
          if (bus.start) latch   = 1'b1;
          else           state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (latch) begin
      tap_d = bus.tap_in;
      rnd_d = SEED;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rnd_q   <= SEED;
      tap_q   <= '{default: '0};
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rnd_q   <= rnd_d;
      tap_q   <= tap_d;
      valid_q <= run;
      done_q  <= run & last;
    end
  end

  for (genvar g = 0; g < TAPS; g++) begin : g_lane
    sc_sng_lane #(.W(W), .REV(g % 2 == 1)) u_lane (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (run),
      .tap_i (tap_q[g]),
      .rnd_i (rnd_q),
      .sc_o  (sc_q[g])
    );
  end

  assign bus.sc_out      = sc_q;
  assign bus.sc_valid    = valid_q;
  assign bus.window_done = done_q;
  assign bus.busy        = run;
endmodule

// File: tb/tb_sc_sng_bank.sv
// tb_sc_sng_bank: directed windows; expected per-window popcounts are queued
// at issue time and a negedge monitor pops/compares on each window_done.
module tb_sc_sng_bank;
  localparam int TAPS = 39;
  localparam int W    = 8;
  localparam int L    = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sc_sng_bank_if #(.TAPS(TAPS), .W(W)) bus ();
  sc_sng_bank_if #(.TAPS(TAPS), .W(W)) bus0 ();

  sc_sng_bank #(.TAPS(TAPS), .W(W), .POLY(8'hB8), .SEED(8'h01)) u_dut (
    .clk_i (clk), .rst_i (rst), .bus (bus.slave));
  sc_sng_bank #(.TAPS(TAPS), .W(W), .POLY(8'hB8), .SEED(8'h00)) u_dut0 (
    .clk_i (clk), .rst_i (rst), .bus (bus0.slave));

  int ntests = 0;
  int nfail  = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  typedef struct {
    int pc [TAPS];
    bit contig;
    bit decor;
  } exp_t;

  exp_t sbq [$];
  int   tv  [TAPS];

  // ---------------- monitor / scoreboard ----------------
  int     acc [TAPS];
  int     len, andc, difc;
  longint cyc, last_done;
  exp_t   me;

  always @(negedge clk) begin
    if (rst) begin
      foreach (acc[i]) acc[i] = 0;
      len = 0; andc = 0; difc = 0;
    end else begin
      cyc++;
      if (!bus.sc_valid) chk("idle_out_zero", int'(bus.sc_out != '0), 0);
      if (bus.sc_valid) begin
        for (int i = 0; i < TAPS; i++) acc[i] += int'(bus.sc_out[i]);
        len++;
        andc += int'(bus.sc_out[0] & bus.sc_out[1]);
        difc += int'(bus.sc_out[0] ^ bus.sc_out[1]);
      end
      if (bus.window_done) begin
        if (sbq.size() == 0) begin
          ntests++; nfail++;
          $display("FAIL unexpected_window: got window_done at cycle %0d expected none", cyc);
        end else begin
          me = sbq.pop_front();
          chk("window_len", len, L);
          for (int i = 0; i < TAPS; i++)
            chk($sformatf("popcount_tap%0d", i), acc[i], me.pc[i]);
          if (me.contig) chk("b2b_spacing", int'(cyc - last_done), L);
          if (me.decor) begin
            chk("decor_and_in_64pm16", int'(andc >= 48 && andc <= 80), 1);
            chk("decor_streams_differ", int'(difc > 0), 1);
          end
        end
        last_done = cyc;
        foreach (acc[i]) acc[i] = 0;
        len = 0; andc = 0; difc = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply_taps();
    for (int i = 0; i < TAPS; i++) bus.tap_in[i] = W'(tv[i]);
  endtask

  task automatic push_exp(input bit contig, input bit decor);
    exp_t e;
    e.pc = tv;
    e.contig = contig;
    e.decor  = decor;
    sbq.push_back(e);
  endtask

  task automatic check_outputs_zero(input string nm);
    chk({nm, "_busy"},  int'(bus.busy), 0);
    chk({nm, "_valid"}, int'(bus.sc_valid), 0);
    chk({nm, "_done"},  int'(bus.window_done), 0);
    chk({nm, "_out"},   int'(bus.sc_out != '0), 0);
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while ((bus.busy || sbq.size() != 0) && k < 3000) begin
      @(negedge clk); k++;
    end
    chk({nm, "_completes"}, int'(k < 3000), 1);
    repeat (3) @(negedge clk);
    chk({nm, "_no_trailing_valid"}, len, 0);
    chk({nm, "_idle_after"}, int'(bus.busy), 0);
  endtask

  int seen1 [256];
  int seen0 [256];

  initial begin
    int once1, once0;
    bus.start  = 1'b0;
    bus0.start = 1'b0;
    foreach (tv[i]) tv[i] = 0;
    for (int i = 0; i < TAPS; i++) begin
      bus.tap_in[i]  = '0;
      bus0.tap_in[i] = '0;
    end
    cyc = 0; last_done = 0;

    // Reset state.
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-window at cnt = 100.
    foreach (tv[i]) tv[i] = 100;
    apply_taps();
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;          // RUN, cnt = 0
    repeat (100) @(negedge clk);               // cnt = 100
    chk("cnt_reaches_100", int'(u_dut.cnt_q), 100);
    chk("busy_mid_window", int'(bus.busy), 1);
    #2 rst = 1'b1;
    #1 check_outputs_zero("async_reset");
    @(negedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check_outputs_zero("post_reset");

    // Exact encoding + RNG permutation for SEED 01 and 00.
    tv[0] = 0; tv[1] = 1; tv[2] = 128; tv[3] = 255;
    for (int i = 4; i < TAPS; i++) tv[i] = (37 * i) % 256;
    apply_taps();
    push_exp(1'b0, 1'b0);
    foreach (seen1[v]) begin seen1[v] = 0; seen0[v] = 0; end
    bus.start = 1'b1; bus0.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; bus0.start = 1'b0;
    for (int k = 0; k < L; k++) begin
      seen1[u_dut.rnd_q]++;
      seen0[u_dut0.rnd_q]++;
      @(negedge clk);
    end
    once1 = 0; once0 = 0;
    foreach (seen1[v]) begin
      once1 += int'(seen1[v] == 1);
      once0 += int'(seen0[v] == 1);
    end
    chk("rng_perm_seed01", once1, 256);
    chk("rng_perm_seed00", once0, 256);
    wait_idle("encode");

    // Snapshot isolation: tap_in change and mid-window start ignored.
    foreach (tv[i]) tv[i] = 200;
    apply_taps();
    push_exp(1'b0, 1'b0);
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;          // cnt = 0
    repeat (10) @(negedge clk);                // cnt = 10
    for (int i = 0; i < TAPS; i++) bus.tap_in[i] = 8'd5;
    repeat (40) @(negedge clk);                // cnt = 50
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    wait_idle("snapshot");

    // Back-to-back windows: 64 then 192, start held high.
    foreach (tv[i]) tv[i] = 64;
    apply_taps();
    push_exp(1'b0, 1'b0);
    bus.start = 1'b1;
    repeat (5) @(negedge clk);                 // window 1, cnt = 4
    foreach (tv[i]) tv[i] = 192;
    apply_taps();
    push_exp(1'b1, 1'b0);
    repeat (255) @(negedge clk);               // window 2, cnt = 3
    bus.start = 1'b0;
    wait_idle("b2b");

    // Decorrelation of neighbouring taps.
    foreach (tv[i]) tv[i] = 0;
    tv[0] = 128; tv[1] = 128;
    apply_taps();
    push_exp(1'b0, 1'b1);
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    wait_idle("decor");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
